alu_decode_stage: RTL and testbench

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

---
 rtl/alu_decode_stage_pkg.sv | 57 +++++
 rtl/alu_op_decoder.sv | 35 +++
 rtl/alu_decode_stage.sv | 62 ++++++
 tb/tb_alu_decode_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_decode_stage_pkg.sv
// alu_decode_stage_pkg: ALU op codes, opcode/funct7 constants and decode records shared with the ALU.
// RV32M_DECODE_EN enables the M-extension ALU codes.
package alu_decode_stage_pkg;
  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SLL  = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1001,
    ALU_SRA  = 4'b1010,
    ALU_MUL  = 4'b1011,
    ALU_DIV  = 4'b1100,
    ALU_REM  = 4'b1101
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

`ifdef RV32M_DECODE_EN
  localparam bit M_BUILD = 1'b1;
`else
  localparam bit M_BUILD = 1'b0;
`endif

  typedef struct packed {
    alu_op_t op;
    logic    use_imm;
    logic    illegal;
  } dec_t;

  typedef struct packed {
    logic [31:0] instr;
    dec_t        dec;
  } entry_t;

  function automatic alu_op_t base_op(input logic [2:0] f3);
    return f3 == 3'b000 ? ALU_ADD  : f3 == 3'b001 ? ALU_SLL :
           f3 == 3'b010 ? ALU_SLT  : f3 == 3'b011 ? ALU_SLTU :
           f3 == 3'b100 ? ALU_XOR  : f3 == 3'b101 ? ALU_SRL :
           f3 == 3'b110 ? ALU_OR   : ALU_AND;
  endfunction
endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: combinational RV32 instruction to ALU op / immediate-select / illegal decode.
// RV32M_DECODE_EN (via the package) enables MUL/DIV/REM decode.
module alu_op_decoder
  import alu_decode_stage_pkg::*;
#(
  parameter int M_CODES = 1
) (
  input  logic [31:0] instr,
  output dec_t        dec
);
  localparam bit M_ON = M_BUILD && (M_CODES == 1);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  always_comb begin
    dec = '{ALU_AND, 1'b0, 1'b1};
    case (opc)
      OPC_OP:
        if (f7 == F7_BASE) dec = '{base_op(f3), 1'b0, 1'b0};
        else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) dec = '{f3[2] ? ALU_SRA : ALU_SUB, 1'b0, 1'b0};
        else if (f7 == F7_MULDIV && M_ON && (f3 == 3'b000 || f3[2])) dec = '{f3 == 3'b000 ? ALU_MUL : f3[1] ? ALU_REM : ALU_DIV, 1'b0, 1'b0};
      // Only the shift-immediates constrain instr[31:25]; other funct3 treat it as immediate bits.
      OPC_OP_IMM:
        if (f3 == 3'b001 ? f7 == F7_BASE : f3 == 3'b101 ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1)
          dec = '{(f3 == 3'b101 && f7 == F7_ALT) ? ALU_SRA : base_op(f3), 1'b1, 1'b0};
      OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
        dec = '{ALU_ADD, 1'b1, 1'b0};
      OPC_BRANCH:
        if (f3[2:1] != 2'b01) dec = '{!f3[2] ? ALU_SUB : f3[1] ? ALU_SLTU : ALU_SLT, 1'b0, 1'b0};
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: 2-entry skid buffer holding decoded instructions for the ALU.
// RV32M_DECODE_EN selects M-extension decode in alu_op_decoder.
module alu_decode_stage
  import alu_decode_stage_pkg::*;
#(
  parameter int M_CODES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [3:0]  out_alu_control,
  output logic        out_use_imm,
  output logic        out_illegal
);
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  logic [1:0] state, nxt;
  logic       rdy, push, pop;
  dec_t       dec;
  entry_t     head, tail, fresh;
  alu_op_decoder #(.M_CODES(M_CODES)) u_dec (
    .instr(in_instr),
    .dec  (dec)
  );
  assign fresh           = {in_instr, dec};
  assign in_ready        = rdy;
  assign out_valid       = state != S_EMPTY;
  assign push            = in_valid && rdy;
  assign pop             = out_valid && out_ready;
  assign out_instr       = head.instr;
  assign out_alu_control = head.dec.op;
  assign out_use_imm     = head.dec.use_imm;
  assign out_illegal     = head.dec.illegal;
  always_comb
    nxt = flush            ? S_EMPTY :
          state == S_EMPTY ? (push ? S_ONE : S_EMPTY) :
          state == S_ONE   ? (push && !pop ? S_FULL : !push && pop ? S_EMPTY : S_ONE) :
                             (pop ? S_ONE : S_FULL);
  // in_ready is a flop fed from the next state, so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_EMPTY;
      rdy   <= 1'b0;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= nxt;
      rdy   <= nxt != S_FULL;
      if (!flush) begin
        if (state == S_FULL && pop) head <= tail;
        else if (push && (state == S_EMPTY || pop)) head <= fresh;
        if (state == S_ONE && push && !pop) tail <= fresh;
      end
    end
endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: table-driven decode vectors through a scoreboard, plus stall/flush/reset sequences.
module tb_alu_decode_stage;
  typedef struct {
    logic [31:0] instr;
    logic [3:0]  code;
    logic        imm;
    logic        ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [3:0]  out_alu_control;
  logic        out_use_imm;
  logic        out_illegal;

  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];
  vec_t q[$];
  vec_t cur;

  alu_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_alu_control(out_alu_control), .out_use_imm(out_use_imm), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] i, input logic [3:0] c, input logic m, input logic l);
    vec_t v;
    v.instr = i; v.code = c; v.imm = m; v.ill = l;
    tbl.push_back(v);
  endtask

  task automatic offer(input vec_t v);
    in_valid = 1'b1;
    in_instr = v.instr;
    cur = v;
  endtask

  // Compare the head against the oldest expected entry, then advance one edge and update the scoreboard.
  task automatic step();
    bit fl, pu, po;
    fl = flush;
    pu = in_valid && in_ready && !fl;
    po = out_valid && out_ready;
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    if (out_valid && q.size() != 0) begin
      chk($sformatf("instr %h", q[0].instr), out_instr, q[0].instr);
      chk($sformatf("alu_control %h", q[0].instr), {28'b0, out_alu_control}, {28'b0, q[0].code});
      chk($sformatf("use_imm %h", q[0].instr), {31'b0, out_use_imm}, {31'b0, q[0].imm});
      chk($sformatf("illegal %h", q[0].instr), {31'b0, out_illegal}, {31'b0, q[0].ill});
    end
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (po && q.size() != 0) void'(q.pop_front());
      if (pu) q.push_back(cur);
    end
  endtask

  initial begin
    add(32'h00B50533, 4'b0010, 1'b0, 1'b0);
    add(32'h40B55533, 4'b1010, 1'b0, 1'b0);
    add(32'h4015D513, 4'b1010, 1'b1, 1'b0);
    add(32'h40B50533, 4'b0110, 1'b0, 1'b0);
    add(32'h00B51533, 4'b0011, 1'b0, 1'b0);
    add(32'h00B52533, 4'b0111, 1'b0, 1'b0);
    add(32'h00B53533, 4'b1001, 1'b0, 1'b0);
    add(32'h00B54533, 4'b0100, 1'b0, 1'b0);
    add(32'h00B55533, 4'b0101, 1'b0, 1'b0);
    add(32'h00B56533, 4'b0001, 1'b0, 1'b0);
    add(32'h00B57533, 4'b0000, 1'b0, 1'b0);
    add(32'h40B51533, 4'b0000, 1'b0, 1'b1);
    add(32'h04B50533, 4'b0000, 1'b0, 1'b1);
    add(32'h00158513, 4'b0010, 1'b1, 1'b0);
    add(32'h00159513, 4'b0011, 1'b1, 1'b0);
    add(32'h40159513, 4'b0000, 1'b0, 1'b1);
    add(32'h0015A513, 4'b0111, 1'b1, 1'b0);
    add(32'h0015D513, 4'b0101, 1'b1, 1'b0);
    add(32'hFFF5F513, 4'b0000, 1'b1, 1'b0);
    add(32'h0005A503, 4'b0010, 1'b1, 1'b0);
    add(32'h00A5A023, 4'b0010, 1'b1, 1'b0);
    add(32'h12345537, 4'b0010, 1'b1, 1'b0);
    add(32'h00000517, 4'b0010, 1'b1, 1'b0);
    add(32'h0000006F, 4'b0010, 1'b1, 1'b0);
    add(32'h00008067, 4'b0010, 1'b1, 1'b0);
    add(32'h00B50063, 4'b0110, 1'b0, 1'b0);
    add(32'h00B51063, 4'b0110, 1'b0, 1'b0);
    add(32'h00B54063, 4'b0111, 1'b0, 1'b0);
    add(32'h00B57063, 4'b1001, 1'b0, 1'b0);
    add(32'h00B52063, 4'b0000, 1'b0, 1'b1);
    add(32'h0000007F, 4'b0000, 1'b0, 1'b1);
    add(32'h02B51533, 4'b0000, 1'b0, 1'b1);
`ifdef RV32M_DECODE_EN
    add(32'h02B50533, 4'b1011, 1'b0, 1'b0);
    add(32'h02B54533, 4'b1100, 1'b0, 1'b0);
    add(32'h02B56533, 4'b1101, 1'b0, 1'b0);
`else
    add(32'h02B50533, 4'b0000, 1'b0, 1'b1);
    add(32'h02B54533, 4'b0000, 1'b0, 1'b1);
    add(32'h02B56533, 4'b0000, 1'b0, 1'b1);
`endif

    #12;
    chk("reset in_ready", {31'b0, in_ready}, 32'd0);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset out_instr", out_instr, 32'd0);
    chk("reset alu_control", {28'b0, out_alu_control}, 32'd0);
    chk("reset use_imm", {31'b0, out_use_imm}, 32'd0);
    chk("reset illegal", {31'b0, out_illegal}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("in_ready before first edge", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("in_ready after first edge", {31'b0, in_ready}, 32'd1);

    for (int k = 0; k < tbl.size(); k++) begin
      offer(tbl[k]);
      step();
      chk("streaming in_ready", {31'b0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    step();

    out_ready = 1'b0;
    offer(tbl[0]);
    step();
    offer(tbl[1]);
    step();
    chk("in_ready after 2 accepts", {31'b0, in_ready}, 32'd0);
    offer(tbl[2]);
    step();
    step();
    chk("in_ready while full", {31'b0, in_ready}, 32'd0);
    chk("queue depth while full", q.size(), 32'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 6 && (in_valid || q.size() != 0); k++) begin
      if (in_valid && in_ready) begin
        step();
        in_valid = 1'b0;
      end else step();
    end
    chk("drained", q.size(), 32'd0);
    step();

    out_ready = 1'b0;
    offer(tbl[3]);
    step();
    offer(tbl[4]);
    step();
    chk("full before flush", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    offer(tbl[5]);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush in_ready", {31'b0, in_ready}, 32'd1);
    step();
    step();

    offer(tbl[6]);
    step();
    in_valid = 1'b0;
    chk("one entry before reset", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("async reset in_ready", {31'b0, in_ready}, 32'd0);
    chk("async reset out_instr", out_instr, 32'd0);
    q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("in_ready held after reset", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("in_ready back after reset", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    offer(tbl[1]);
    step();
    in_valid = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
